// File: rtl/score_to_decimal_digits_pkg.sv
// ---------------------------------------------------------------------------
// score_dec_pkg
// Shared definitions for the score-to-decimal-digits converter:
//   DIGIT_W      width of one BCD digit
//   DASH_CODE    nibble shown on every digit when the score overflows
//   state_e      converter FSM states
//   max_decimal  largest value displayable with n decimal digits (10^n - 1)
// ---------------------------------------------------------------------------
package score_dec_pkg;

    localparam int unsigned DIGIT_W   = 4;
    localparam logic [3:0]  DASH_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic [31:0] max_decimal(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p - 32'd1;
    endfunction

endpackage

// File: rtl/score_to_decimal_digits_bcd_add3_adjust.sv
// ---------------------------------------------------------------------------
// bcd_add3_adjust
// Combinational double-dabble correction for one BCD nibble: a nibble of 5 or
// more gets +3 so that the following left shift carries correctly into the
// next decimal digit.
//   nib_i  4-bit BCD digit before correction
//   nib_o  4-bit digit after the conditional +3
// ---------------------------------------------------------------------------
module bcd_add3_adjust
    import score_dec_pkg::*;
(
    input  logic [DIGIT_W-1:0] nib_i,
    output logic [DIGIT_W-1:0] nib_o
);

    always_comb begin
        if (nib_i >= 4'd5) begin
            nib_o = nib_i + 4'd3;
        end else begin
            nib_o = nib_i;
        end
    end

endmodule

// File: rtl/score_to_decimal_digits.sv
// ---------------------------------------------------------------------------
// score_to_decimal_digits
// Iterative binary-to-BCD converter (shift-and-add-3, one bit per clock) that
// feeds the per-digit seven-segment encoders.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; outputs hold the last result
//   SHIFT | one add-3/shift step per clock, BIN_W steps in total
//   DONE  | one-cycle done pulse; digits/overflow/digit_valid are new
//
// Ports:
//   clock        system clock, rising edge
//   resetn       asynchronous active-low reset
//   start        conversion request, sampled only in IDLE
//   value        binary score, captured when start is accepted
//   busy         high while shifting
//   done         one-cycle completion pulse
//   digits       packed BCD digits, [3:0] = ones; all 4'hF on overflow
//   overflow     last score exceeded 10^NUM_DIGITS - 1
//   digit_valid  per-digit display enable
//
// Optional feature macro: SCORE_DEC_LZ_BLANK_EN (leading-zero blanking on
// digit_valid). Without it digit_valid is constant all ones.
// ---------------------------------------------------------------------------
module score_to_decimal_digits
    import score_dec_pkg::*;
#(
    parameter int BIN_W      = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [BIN_W-1:0]              value,
    output logic                          busy,
    output logic                          done,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic                          overflow,
    output logic [NUM_DIGITS-1:0]         digit_valid
);

    localparam int          ACC_W    = DIGIT_W * NUM_DIGITS;
    localparam int          CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [31:0] MAX_DEC  = max_decimal(NUM_DIGITS);

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [ACC_W-1:0]   digits_q, digits_d;
    logic               overflow_q, overflow_d;
    logic [ACC_W-1:0]   bcd_adj;
    logic [31:0]        value_ext;

    assign value_ext = 32'(value);

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_add3_adjust u_adj (
            .nib_i (bcd_q[g*DIGIT_W +: DIGIT_W]),
            .nib_o (bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d    = value;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (value_ext > MAX_DEC);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // Accumulator and shift register move left as one word.
                bcd_d   = {bcd_adj[ACC_W-2:0], shreg_q[BIN_W-1]};
                shreg_d = {shreg_q[BIN_W-2:0], 1'b0};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Results are registered on the final shift so that they
                    // are already visible during the DONE cycle.
                    digits_d   = ovf_pend_q ? {NUM_DIGITS{DASH_CODE}} : bcd_d;
                    overflow_d = ovf_pend_q;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef SCORE_DEC_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] valid_q, valid_d;
    logic [NUM_DIGITS-1:0] lz_valid;
    logic                  lz_seen;

    // Enable every digit from the most significant non-zero one downwards;
    // the ones digit is always shown so that zero displays as "0".
    always_comb begin
        lz_valid = '0;
        lz_seen  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (bcd_d[i*DIGIT_W +: DIGIT_W] != '0) begin
                lz_seen = 1'b1;
            end
            lz_valid[i] = lz_seen;
        end
        lz_valid[0] = 1'b1;
    end

    always_comb begin
        valid_d = valid_q;
        if (state_q == SHIFT && cnt_q == CNT_LAST) begin
            valid_d = ovf_pend_q ? '1 : lz_valid;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q <= NUM_DIGITS'(1);
        end else begin
            valid_q <= valid_d;
        end
    end

    assign digit_valid = valid_q;
`else
    assign digit_valid = '1;
`endif

    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign digits   = digits_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_score_to_decimal_digits.sv
module tb_score_to_decimal_digits;

    localparam int BIN_W      = 16;
    localparam int NUM_DIGITS = 4;
    localparam int LAT        = BIN_W + 1;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [15:0] value;
    logic        busy;
    logic        done;
    logic [15:0] digits;
    logic        overflow;
    logic [3:0]  digit_valid;

    int errors = 0;
    int checks = 0;

    score_to_decimal_digits #(
        .BIN_W      (BIN_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .value       (value),
        .busy        (busy),
        .done        (done),
        .digits      (digits),
        .overflow    (overflow),
        .digit_valid (digit_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model (decimal arithmetic) ----------------
    function automatic logic [15:0] model_digits(input int v);
        logic [15:0] r;
        int          p;
        if (v > 9999) return 16'hFFFF;
        r = '0;
        p = 1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[i*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] model_valid(input int v);
`ifdef SCORE_DEC_LZ_BLANK_EN
        int nd;
        int t;
        if (v > 9999) return 4'hF;
        nd = 1;
        t  = v / 10;
        while (t > 0) begin
            nd++;
            t = t / 10;
        end
        return 4'((1 << nd) - 1);
`else
        return 4'hF + 4'(v & 0);
`endif
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    // Leaves the caller at the falling edge inside cycle 1 (cycle 0 = start).
    task automatic start_conv(input logic [15:0] v);
        @(negedge clock);
        start = 1'b1;
        value = v;
        @(negedge clock);
        start = 1'b0;
        value = 16'($urandom);
    endtask

    task automatic wait_done(input int k0, input int kmax,
                             output int done_cyc, output int busy_cnt,
                             output int done_cnt, output logic [15:0] dig,
                             output logic ovf, output logic [3:0] dv,
                             output logic busy_at_done);
        done_cyc = -1; busy_cnt = 0; done_cnt = 0;
        dig = 'x; ovf = 'x; dv = 'x; busy_at_done = 'x;
        for (int k = k0; k <= kmax; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = k;
                    dig          = digits;
                    ovf          = overflow;
                    dv           = digit_valid;
                    busy_at_done = busy;
                end
            end
            if (k < kmax) @(negedge clock);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [3:0] exp_dv;
`ifdef SCORE_DEC_LZ_BLANK_EN
        exp_dv = 4'b0001;
`else
        exp_dv = 4'b1111;
`endif
        resetn = 1'b0; start = 1'b0; value = '0;
        repeat (3) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (digits !== 16'h0) begin errors++; $display("FAIL reset_digits got=%h exp=0000", digits); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (digit_valid !== exp_dv) begin errors++; $display("FAIL reset_digit_valid got=%b exp=%b", digit_valid, exp_dv); end
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_convert(input int v, input string tag);
        int dc, bc, dn;
        logic [15:0] dg; logic ov, bd; logic [3:0] dv;
        start_conv(16'(v));
        wait_done(1, LAT + 3, dc, bc, dn, dg, ov, dv, bd);
        checks++; if (dc !== LAT) begin errors++; $display("FAIL %s done_cycle got=%0d exp=%0d", tag, dc, LAT); end
        checks++; if (bc !== BIN_W) begin errors++; $display("FAIL %s busy_cycles got=%0d exp=%0d", tag, bc, BIN_W); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL %s done_pulses got=%0d exp=1", tag, dn); end
        checks++; if (bd !== 1'b0) begin errors++; $display("FAIL %s busy_in_done got=%b exp=0", tag, bd); end
        checks++; if (dg !== model_digits(v)) begin errors++; $display("FAIL %s digits got=%h exp=%h", tag, dg, model_digits(v)); end
        checks++; if (ov !== (v > 9999)) begin errors++; $display("FAIL %s overflow got=%b exp=%b", tag, ov, v > 9999); end
        checks++; if (dv !== model_valid(v)) begin errors++; $display("FAIL %s digit_valid got=%b exp=%b", tag, dv, model_valid(v)); end
        checks++; if (digits !== model_digits(v)) begin errors++; $display("FAIL %s digits_hold got=%h exp=%h", tag, digits, model_digits(v)); end
    endtask

    task automatic test_directed();
        test_convert(1234, "conv_1234");
        test_convert(0, "conv_zero");
        test_convert(9999, "conv_max");
        test_convert(10000, "ovf_10000");
        test_convert(65535, "ovf_65535");
    endtask

    task automatic test_blanking();
        int vals [3] = '{7, 305, 0};
        logic [3:0] exp [3];
`ifdef SCORE_DEC_LZ_BLANK_EN
        exp = '{4'b0001, 4'b0111, 4'b0001};
`else
        exp = '{4'b1111, 4'b1111, 4'b1111};
`endif
        for (int i = 0; i < 3; i++) begin
            start_conv(16'(vals[i]));
            repeat (LAT + 1) @(negedge clock);
            checks++;
            if (digit_valid !== exp[i]) begin
                errors++;
                $display("FAIL blank_%0d digit_valid got=%b exp=%b", vals[i], digit_valid, exp[i]);
            end
        end
    endtask

    task automatic test_ignored_start();
        int dc, bc, dn;
        logic [15:0] dg; logic ov, bd; logic [3:0] dv;
        start_conv(16'd1234);
        repeat (4) @(negedge clock);
        start = 1'b1; value = 16'd42;
        @(negedge clock);
        start = 1'b0;
        wait_done(6, 2 * LAT + 4, dc, bc, dn, dg, ov, dv, bd);
        checks++; if (dn !== 1) begin errors++; $display("FAIL ignored_start done_pulses got=%0d exp=1", dn); end
        checks++; if (dc !== LAT) begin errors++; $display("FAIL ignored_start done_cycle got=%0d exp=%0d", dc, LAT); end
        checks++; if (dg !== 16'h1234) begin errors++; $display("FAIL ignored_start digits got=%h exp=1234", dg); end
        checks++; if (digits !== 16'h1234) begin errors++; $display("FAIL ignored_start digits_hold got=%h exp=1234", digits); end
    endtask

    task automatic test_reset_mid();
        int dc, bc, dn;
        logic [15:0] dg; logic ov, bd; logic [3:0] dv;
        start_conv(16'd1234);
        repeat (7) @(negedge clock);
        resetn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset busy got=%b exp=0", busy); end
        checks++; if (digits !== 16'h0) begin errors++; $display("FAIL mid_reset digits got=%h exp=0000", digits); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_reset done got=%b exp=0", done); end
        @(negedge clock);
        resetn = 1'b1;
        wait_done(1, LAT + 4, dc, bc, dn, dg, ov, dv, bd);
        checks++; if (dn !== 0) begin errors++; $display("FAIL mid_reset done_pulses got=%0d exp=0", dn); end
        checks++; if (bc !== 0) begin errors++; $display("FAIL mid_reset busy_cycles got=%0d exp=0", bc); end
        test_convert(7, "after_reset_7");
    endtask

    task automatic test_random();
        int v;
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 99));
                1:       v = int'($urandom_range(100, 9999));
                2:       v = int'($urandom_range(9990, 10010));
                default: v = int'($urandom_range(0, 65535));
            endcase
            test_convert(v, $sformatf("rand_%0d", v));
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; value = '0;
        test_reset();
        test_directed();
        test_blanking();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
